// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: operation codes and control states.
package alu_pkg;

  localparam int OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_XOR   = 4'd2,
    OP_ANDN  = 4'd3,
    OP_SLL   = 4'd4,
    OP_SRL   = 4'd5,
    OP_ROL   = 4'd6,
    OP_ROR   = 4'd7,
    OP_BTR   = 4'd8,
    OP_SEQ   = 4'd9,
    OP_SLT   = 4'd10,
    OP_SLE   = 4'd11,
    OP_SCO   = 4'd12,
    OP_PASSB = 4'd13,
    OP_MUL   = 4'd14
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/alu_pipe_dp.sv
// Combinational datapath for every single-cycle operation; MUL and unused codes yield zero.
module alu_pipe_dp
  import alu_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int SH_W  = $clog2(WIDTH)
) (
  input  logic [OP_W-1:0]  op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] result_o,
  output logic             cout_o,
  output logic             ofl_o
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [SH_W-1:0]  shamt;
  logic [SH_W:0]    invAmt;
  logic [WIDTH-1:0] rev;
  logic             isEq;
  logic             isLt;

  // Shared arithmetic terms; SUB is formed as B + ~A + 1 so its carry is the adder carry.
  always_comb begin
    sum    = {1'b0, a_i} + {1'b0, b_i};
    diff   = {1'b0, b_i} + {1'b0, ~a_i} + {{WIDTH{1'b0}}, 1'b1};
    shamt  = b_i[SH_W-1:0];
    invAmt = (SH_W+1)'(WIDTH) - {1'b0, shamt};
    isEq   = (a_i == b_i);
    isLt   = ($signed(a_i) < $signed(b_i));
    for (int i = 0; i < WIDTH; i++) begin
      rev[i] = a_i[WIDTH-1-i];
    end
  end

  always_comb begin
    result_o = '0;
    cout_o   = 1'b0;
    ofl_o    = 1'b0;
    case (op_i)
      OP_ADD: begin
        result_o = sum[WIDTH-1:0];
        cout_o   = sum[WIDTH];
        ofl_o    = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_SUB: begin
        result_o = diff[WIDTH-1:0];
        cout_o   = diff[WIDTH];
        ofl_o    = (b_i[WIDTH-1] != a_i[WIDTH-1]) && (diff[WIDTH-1] != b_i[WIDTH-1]);
      end
      OP_XOR:   result_o = a_i ^ b_i;
      OP_ANDN:  result_o = a_i & ~b_i;
      OP_SLL:   result_o = a_i << shamt;
      OP_SRL:   result_o = a_i >> shamt;
      // A shift by the full width gives zero, so amount 0 rotates cleanly too.
      OP_ROL:   result_o = (a_i << shamt) | (a_i >> invAmt);
      OP_ROR:   result_o = (a_i >> shamt) | (a_i << invAmt);
      OP_BTR:   result_o = rev;
      OP_SEQ:   result_o = {{(WIDTH-1){1'b0}}, isEq};
      OP_SLT:   result_o = {{(WIDTH-1){1'b0}}, isLt};
      OP_SLE:   result_o = {{(WIDTH-1){1'b0}}, isLt | isEq};
      OP_SCO: begin
        result_o = {{(WIDTH-1){1'b0}}, sum[WIDTH]};
        cout_o   = sum[WIDTH];
      end
      OP_PASSB: result_o = b_i;
      default: begin
        result_o = '0;
        cout_o   = 1'b0;
        ofl_o    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked execution unit: single-cycle ops through the datapath, MUL by iterative shift-add.
module alu_pipe
  import alu_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int TAG_W = 3,
  localparam int SH_W  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_cout,
  output logic             out_ofl
);

  state_e state_q, state_d;

  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SH_W-1:0]  cnt_q, cnt_d;
  logic [TAG_W-1:0] mulTag_q, mulTag_d;

  logic             outValid_q, outValid_d;
  logic [WIDTH-1:0] outData_q, outData_d;
  logic [TAG_W-1:0] outTag_q, outTag_d;
  logic             outZero_q, outZero_d;
  logic             outNeg_q, outNeg_d;
  logic             outCout_q, outCout_d;
  logic             outOfl_q, outOfl_d;

  logic             inReady;
  logic             mulBusy;
  logic             mulDone;
  logic             accept;
  logic             isMul;
  logic [WIDTH-1:0] accStep;
  logic [WIDTH-1:0] dpResult;
  logic             dpCout;
  logic             dpOfl;

  alu_pipe_dp #(
    .WIDTH(WIDTH)
  ) u_dp (
    .op_i    (in_op),
    .a_i     (in_a),
    .b_i     (in_b),
    .result_o(dpResult),
    .cout_o  (dpCout),
    .ofl_o   (dpOfl)
  );

  assign isMul   = (in_op == OP_MUL);
  assign accept  = in_valid && inReady;
  assign accStep = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept && isMul) state_d = ST_MUL;
      ST_MUL:  if (flush || (cnt_q == '0)) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // A new op may enter only when idle and the result slot is empty or being drained.
  always_comb begin
    mulBusy = (state_q == ST_MUL);
    mulDone = mulBusy && !flush && (cnt_q == '0);
    inReady = (state_q == ST_IDLE) && !flush && (!outValid_q || out_ready);
  end

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    mulTag_d = mulTag_q;
    if (accept && isMul) begin
      mcand_d  = in_a;
      mplier_d = in_b;
      acc_d    = '0;
      cnt_d    = SH_W'(WIDTH - 1);
      mulTag_d = in_tag;
    end else if (mulBusy && !flush) begin
      acc_d    = accStep;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - 1'b1;
    end
  end

  // Flush wins over everything; a finishing MUL and a single-cycle accept never coincide.
  always_comb begin
    outValid_d = outValid_q;
    outData_d  = outData_q;
    outTag_d   = outTag_q;
    outZero_d  = outZero_q;
    outNeg_d   = outNeg_q;
    outCout_d  = outCout_q;
    outOfl_d   = outOfl_q;
    if (flush) begin
      outValid_d = 1'b0;
    end else if (mulDone) begin
      outValid_d = 1'b1;
      outData_d  = accStep;
      outTag_d   = mulTag_q;
      outZero_d  = (accStep == '0);
      outNeg_d   = accStep[WIDTH-1];
      outCout_d  = 1'b0;
      outOfl_d   = 1'b0;
    end else if (accept && !isMul) begin
      outValid_d = 1'b1;
      outData_d  = dpResult;
      outTag_d   = in_tag;
      outZero_d  = (dpResult == '0);
      outNeg_d   = dpResult[WIDTH-1];
      outCout_d  = dpCout;
      outOfl_d   = dpOfl;
    end else if (out_ready) begin
      outValid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q    <= '0;
      mplier_q   <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      mulTag_q   <= '0;
      outValid_q <= 1'b0;
      outData_q  <= '0;
      outTag_q   <= '0;
      outZero_q  <= 1'b0;
      outNeg_q   <= 1'b0;
      outCout_q  <= 1'b0;
      outOfl_q   <= 1'b0;
    end else begin
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      mulTag_q   <= mulTag_d;
      outValid_q <= outValid_d;
      outData_q  <= outData_d;
      outTag_q   <= outTag_d;
      outZero_q  <= outZero_d;
      outNeg_q   <= outNeg_d;
      outCout_q  <= outCout_d;
      outOfl_q   <= outOfl_d;
    end
  end

  assign in_ready  = inReady;
  assign out_valid = outValid_q;
  assign out_data  = outData_q;
  assign out_tag   = outTag_q;
  assign out_zero  = outZero_q;
  assign out_neg   = outNeg_q;
  assign out_cout  = outCout_q;
  assign out_ofl   = outOfl_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: directed corner cases, then randomized traffic with flushes.
module tb_alu_pipe;

  localparam int W  = 16;
  localparam int TW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_op;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [TW-1:0] out_tag;
  logic          out_zero;
  logic          out_neg;
  logic          out_cout;
  logic          out_ofl;

  typedef struct {
    logic [W-1:0]  data;
    logic [TW-1:0] tag;
    logic          zero;
    logic          neg;
    logic          cout;
    logic          ofl;
    int            due;
  } exp_t;

  exp_t sbQ[$];
  int   nVec      = 0;
  int   nMis      = 0;
  int   cyc       = 0;
  bit   headSeen  = 1'b0;
  int   readyMode = 0;

  alu_pipe #(
    .WIDTH(W),
    .TAG_W(TW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_op    (in_op),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_tag  (out_tag),
    .out_zero (out_zero),
    .out_neg  (out_neg),
    .out_cout (out_cout),
    .out_ofl  (out_ofl)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference behaviour computed with plain integer arithmetic
  function automatic exp_t refModel(input logic [3:0] op, input logic [W-1:0] a,
                                    input logic [W-1:0] b, input logic [TW-1:0] tag);
    exp_t e;
    int ua, ub, sa, sb, n, r, mask, maxS, minS;
    longint unsigned p;
    ua   = int'(a);
    ub   = int'(b);
    sa   = int'($signed(a));
    sb   = int'($signed(b));
    n    = ub % W;
    mask = (1 << W) - 1;
    maxS = (1 << (W - 1)) - 1;
    minS = -(1 << (W - 1));
    r      = 0;
    e.cout = 1'b0;
    e.ofl  = 1'b0;
    case (op)
      4'd0: begin
        r      = ua + ub;
        e.cout = ((r >> W) & 1) == 1;
        e.ofl  = (sa + sb > maxS) || (sa + sb < minS);
      end
      4'd1: begin
        r      = ub + ((~ua) & mask) + 1;
        e.cout = ((r >> W) & 1) == 1;
        e.ofl  = (sb - sa > maxS) || (sb - sa < minS);
      end
      4'd2:  r = ua ^ ub;
      4'd3:  r = ua & ~ub;
      4'd4:  r = ua << n;
      4'd5:  r = ua >> n;
      4'd6:  r = (ua << n) | (ua >> (W - n));
      4'd7:  r = (ua >> n) | (ua << (W - n));
      4'd8: begin
        for (int i = 0; i < W; i++) begin
          if (((ua >> i) & 1) == 1) r = r | (1 << (W - 1 - i));
        end
      end
      4'd9:  r = (ua == ub) ? 1 : 0;
      4'd10: r = (sa < sb) ? 1 : 0;
      4'd11: r = (sa <= sb) ? 1 : 0;
      4'd12: begin
        r      = (ua + ub) >> W;
        e.cout = (r != 0);
      end
      4'd13: r = ub;
      4'd14: begin
        p = longint'(ua) * longint'(ub);
        r = int'(p & longint'(mask));
      end
      default: r = 0;
    endcase
    r      = r & mask;
    e.data = r[W-1:0];
    e.zero = (e.data == '0);
    e.neg  = e.data[W-1];
    e.tag  = tag;
    e.due  = 0;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    nVec++;
    if (act !== req) begin
      nMis++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Called in the cycle whose closing edge accepts the op
  task automatic pushExp(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [TW-1:0] tag);
    exp_t e;
    e     = refModel(op, a, b, tag);
    e.due = cyc + 1 + ((op == 4'd14) ? W : 0);
    sbQ.push_back(e);
  endtask

  task automatic applyStimulus(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [TW-1:0] tag);
    int guard;
    guard = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
    #1;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (!in_ready) begin
      nVec++;
      nMis++;
      $display("[TB] FAIL accept-timeout: op %0d never accepted", op);
      in_valid = 1'b0;
      return;
    end
    pushExp(op, a, b, tag);
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic doFlush();
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b1;
    sbQ.delete();
    headSeen = 1'b0;
    #1;
    checkOutput("flush-blocks-ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    checkOutput("flush-clears-valid", {31'd0, out_valid}, 32'd0);
    checkOutput("flush-ready-after", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic doReset();
    @(negedge clk);
    in_valid = 1'b0;
    #3;
    rst = 1'b1;
    sbQ.delete();
    headSeen = 1'b0;
    #1;
    checkOutput("rst-valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst-data", {16'd0, out_data}, 32'd0);
    checkOutput("rst-tag", {29'd0, out_tag}, 32'd0);
    checkOutput("rst-flags", {28'd0, out_zero, out_neg, out_cout, out_ofl}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rst-ready-after", {31'd0, in_ready}, 32'd1);
  endtask

  function automatic logic [W-1:0] randOperand();
    logic [W-1:0] specials [5];
    specials[0] = 16'h0000;
    specials[1] = 16'h0001;
    specials[2] = 16'h7FFF;
    specials[3] = 16'h8000;
    specials[4] = 16'hFFFF;
    if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 4)];
    return W'($urandom);
  endfunction

  // Consumer side: out_ready policy selected by the stimulus thread
  always begin
    @(negedge clk);
    case (readyMode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 1) == 1);
      default: out_ready = 1'b0;
    endcase
  end

  // Monitor: checks first-appearance latency, then pops and compares on each transfer
  always begin
    @(negedge clk);
    #2;
    if (!rst && !flush && out_valid) begin
      if (sbQ.size() == 0) begin
        nVec++;
        nMis++;
        $display("[TB] FAIL spurious-output: out_valid=1 with data 0x%0h, expected no result", out_data);
      end else begin
        if (!headSeen) begin
          checkOutput("latency", cyc, sbQ[0].due);
          headSeen = 1'b1;
        end
        if (out_ready) begin
          checkOutput("data", {16'd0, out_data}, {16'd0, sbQ[0].data});
          checkOutput("tag", {29'd0, out_tag}, {29'd0, sbQ[0].tag});
          checkOutput("flags", {28'd0, out_zero, out_neg, out_cout, out_ofl},
                      {28'd0, sbQ[0].zero, sbQ[0].neg, sbQ[0].cout, sbQ[0].ofl});
          void'(sbQ.pop_front());
          headSeen = 1'b0;
        end
      end
    end
  end

  initial begin
    exp_t eA;
    int   guard;
    int   pick;
    rst      = 1'b1;
    flush    = 1'b0;
    in_valid = 1'b0;
    in_op    = '0;
    in_a     = '0;
    in_b     = '0;
    in_tag   = '0;
    out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset-valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset-data", {16'd0, out_data}, 32'd0);
    checkOutput("reset-flags", {28'd0, out_zero, out_neg, out_cout, out_ofl}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("reset-ready", {31'd0, in_ready}, 32'd1);

    // Single-cycle corner cases, back to back
    applyStimulus(4'd0,  16'h7FFF, 16'h0001, 3'd5);
    applyStimulus(4'd1,  16'h0001, 16'h0001, 3'd1);
    applyStimulus(4'd6,  16'h8001, 16'h0001, 3'd2);
    applyStimulus(4'd7,  16'h0001, 16'h0004, 3'd3);
    applyStimulus(4'd5,  16'h8000, 16'h000F, 3'd4);
    applyStimulus(4'd8,  16'h0001, 16'h0000, 3'd6);
    applyStimulus(4'd10, 16'hFFFF, 16'h0001, 3'd7);
    applyStimulus(4'd11, 16'h1234, 16'h1234, 3'd0);
    applyStimulus(4'd12, 16'hFFFF, 16'h0001, 3'd1);
    applyStimulus(4'd15, 16'h1234, 16'h5678, 3'd2);
    idleCycles(2);

    // MUL: unit busy for the whole iteration
    applyStimulus(4'd14, 16'h0003, 16'h0005, 3'd3);
    for (int k = 0; k < W; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      checkOutput("mul-busy", {30'd0, in_ready, out_valid}, 32'd0);
    end
    idleCycles(2);
    applyStimulus(4'd14, 16'h0100, 16'h0100, 3'd4);
    idleCycles(W + 2);

    // Backpressure: result held, next op stalls until the consumer drains
    readyMode = 2;
    idleCycles(1);
    applyStimulus(4'd0, 16'h1234, 16'h0FF0, 3'd1);
    eA = refModel(4'd0, 16'h1234, 16'h0FF0, 3'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_op    = 4'd2;
      in_a     = 16'hA5A5;
      in_b     = 16'h0FF0;
      in_tag   = 3'd6;
      #1;
      checkOutput("bp-stall", {31'd0, in_ready}, 32'd0);
      checkOutput("bp-hold", {11'd0, out_valid, out_tag, out_data}, {11'd1, eA.tag, eA.data});
    end
    readyMode = 0;
    @(negedge clk);
    #1;
    checkOutput("bp-accept", {31'd0, in_ready}, 32'd1);
    pushExp(4'd2, 16'hA5A5, 16'h0FF0, 3'd6);
    idleCycles(3);

    // Flush five cycles into a MUL
    applyStimulus(4'd14, 16'h1234, 16'h0077, 3'd3);
    idleCycles(4);
    doFlush();
    for (int k = 0; k < W + 2; k++) begin
      @(negedge clk);
      #1;
      checkOutput("flush-no-result", {31'd0, out_valid}, 32'd0);
    end
    applyStimulus(4'd0, 16'h0102, 16'h0304, 3'd5);
    idleCycles(3);

    // Async reset with a held result, then mid-MUL
    readyMode = 2;
    applyStimulus(4'd0, 16'h0005, 16'h0006, 3'd4);
    idleCycles(2);
    #1;
    checkOutput("pre-rst-held", {31'd0, out_valid}, 32'd1);
    doReset();
    readyMode = 0;
    applyStimulus(4'd14, 16'h0007, 16'h0009, 3'd2);
    idleCycles(5);
    doReset();
    idleCycles(W + 2);
    applyStimulus(4'd3, 16'hFFFF, 16'h00FF, 3'd7);
    idleCycles(3);

    // Randomized traffic with random backpressure and occasional flush
    readyMode = 1;
    for (int it = 0; it < 400; it++) begin
      pick = $urandom_range(0, 39);
      if (pick == 0) begin
        doFlush();
      end else if (pick < 8) begin
        idleCycles(1);
      end else begin
        applyStimulus(4'($urandom_range(0, 15)), randOperand(), randOperand(),
                      TW'($urandom_range(0, 7)));
      end
    end

    // Drain whatever is left
    readyMode = 0;
    idleCycles(1);
    guard = 0;
    while (sbQ.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    #3;
    checkOutput("drain-empty", sbQ.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
